instr_prefetch_queue: RTL and testbench

- Instruction prefetch buffer that sits directly upstream of the fetch stage.
- Issues in-order word requests to instruction memory and buffers the returned instructions with their PCs in a DEPTH-entry FIFO.
- Presents the head entry to the fetch stage with a valid/ready handshake.
- On a taken branch or jump from execute (PCSrcE/PCTargetE), flushes all queued and in-flight instructions and restarts fetching at the target.

---
 rtl/instr_prefetch_queue.sv | 158 +++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: in-order imem requests, DEPTH-entry FWFT FIFO, redirect flush.
// Define PFQ_PERF_EN to add the pfq_flush_cnt / pfq_drop_cnt saturating counters.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        InstrF_valid,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  input  logic        InstrF_ready
`ifdef PFQ_PERF_EN
  ,
  output logic [31:0] pfq_flush_cnt,
  output logic [31:0] pfq_drop_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW:0]   ptr_t;
  typedef logic [AW+1:0] sum_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q    [DEPTH];
  logic [31:0] tag_q   [DEPTH];

  ptr_t        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  ptr_t        tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  ptr_t        outstanding_q, outstanding_d, discard_q, discard_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        seen_q, seen_d;

  ptr_t occupancy;
  logic empty, full, req_fire, rsp_drop, enq, deq;

  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign empty     = (occupancy == '0);
  assign full      = (occupancy == DEPTH_P);

  // Credit counts every in-flight request, stale or not, so the FIFO can never overflow.
  assign imem_req_valid = !rst && !PCSrcE &&
                          ((sum_t'(occupancy) + sum_t'(outstanding_q)) < sum_t'(DEPTH_P));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (PCSrcE || (discard_q != '0));
  assign enq            = imem_rsp_valid && !rsp_drop;
  assign deq            = !empty && InstrF_ready && !PCSrcE;

  assign InstrF_valid = !empty;
  assign InstrF       = instr_q[rd_ptr_q[AW-1:0]];
  assign PCF          = pc_q[rd_ptr_q[AW-1:0]];
  // Reads 0 until the first instruction has ever been enqueued after reset.
  assign PCPlus4F     = seen_q ? (PCF + 32'd4) : 32'h0;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    fetch_pc_d    = fetch_pc_q;
    discard_d     = discard_q;
    seen_d        = seen_q | enq;
    outstanding_d = outstanding_q + ptr_t'(req_fire) - ptr_t'(imem_rsp_valid);
    if (PCSrcE) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      fetch_pc_d = PCTargetE;
      // Everything still in flight after this edge belongs to the abandoned path.
      discard_d  = outstanding_q - ptr_t'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_wr_d   = tag_wr_q + ptr_t'(1);
      end
      if (enq) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
        tag_rd_d = tag_rd_q + ptr_t'(1);
      end
      if (deq) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - ptr_t'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      fetch_pc_q    <= RESET_PC;
      seen_q        <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fetch_pc_q    <= fetch_pc_d;
      seen_q        <= seen_d;
    end
  end

  // NOTE: the storage is reset because the head entry is visible on InstrF/PCF right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      if (enq) begin
        instr_q[wr_ptr_q[AW-1:0]] <= imem_rsp_data;
        pc_q[wr_ptr_q[AW-1:0]]    <= tag_q[tag_rd_q[AW-1:0]];
      end
      if (req_fire) tag_q[tag_wr_q[AW-1:0]] <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(enq && full && !deq));
  end

`ifdef PFQ_PERF_EN
  logic [31:0] flush_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (PCSrcE && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (rsp_drop && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign pfq_flush_cnt = flush_cnt_q;
  assign pfq_drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: in-order memory model with latency, queue-based reference
// model, a per-cycle vector table, directed corner sequences and a randomized phase.
module tb_instr_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        InstrF_valid;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        InstrF_ready;
`ifdef PFQ_PERF_EN
  logic [31:0] pfq_flush_cnt, pfq_drop_cnt;
  int          m_flush, m_drop;
`endif

  always #5 clk = ~clk;

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .InstrF_valid   (InstrF_valid),
    .InstrF         (InstrF),
    .PCF            (PCF),
    .PCPlus4F       (PCPlus4F),
    .InstrF_ready   (InstrF_ready)
`ifdef PFQ_PERF_EN
    ,
    .pfq_flush_cnt  (pfq_flush_cnt),
    .pfq_drop_cnt   (pfq_drop_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; bit stale; } flight_t;
  typedef struct {
    bit          req_ready;
    bit          instr_ready;
    bit          exp_req_valid;
    logic [31:0] exp_addr;
    bit          exp_out_valid;
    logic [31:0] exp_pcf;
  } vec_t;

  mreq_t       mem_q[$];
  flight_t     inflight[$];
  logic [31:0] exp_fifo[$];
  logic [31:0] model_pc;
  int          mem_lat   = 1;
  bit          mem_stall = 1'b0;
  bit          drv_pcsrc, drv_req_ready, drv_instr_ready, last_acc;
  logic [31:0] drv_target;
  vec_t        vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: FIFO contents and in-flight requests as plain queues of PCs.
  task automatic model_step();
    bit      exp_rv, exp_ov, acc;
    flight_t f;
    exp_rv = !PCSrcE && ((exp_fifo.size() + inflight.size()) < int'(DEPTH));
    exp_ov = (exp_fifo.size() != 0);
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", imem_req_addr, model_pc);
    check("out_valid", 32'(InstrF_valid), 32'(exp_ov));
    if (exp_ov) begin
      check("PCF", PCF, exp_fifo[0]);
      check("InstrF", InstrF, exp_fifo[0] ^ KEY);
      check("PCPlus4F", PCPlus4F, exp_fifo[0] + 32'd4);
    end
`ifdef PFQ_PERF_EN
    check("flush_cnt", pfq_flush_cnt, 32'(m_flush));
    check("drop_cnt", pfq_drop_cnt, 32'(m_drop));
`endif
    acc = exp_rv && imem_req_ready;
    f   = '{32'h0, 1'b1};
    if (imem_rsp_valid) begin
      check("rsp_has_tag", 32'(inflight.size() != 0), 32'd1);
      if (inflight.size() != 0) f = inflight.pop_front();
    end
    if (PCSrcE) begin
      exp_fifo.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      model_pc = PCTargetE;
`ifdef PFQ_PERF_EN
      m_flush++;
      if (imem_rsp_valid) m_drop++;
`endif
    end else begin
      if (exp_ov && InstrF_ready) void'(exp_fifo.pop_front());
      if (imem_rsp_valid) begin
        if (!f.stale) exp_fifo.push_back(f.pc);
`ifdef PFQ_PERF_EN
        else m_drop++;
`endif
      end
      if (acc) begin
        inflight.push_back('{model_pc, 1'b0});
        model_pc = model_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle: drive at negedge, compare against the model, then book-keep the memory.
  task automatic tick();
    bit rv;
    @(negedge clk);
    rv = (mem_q.size() != 0) && (mem_q[0].due <= cyc) &&
         (!mem_stall || ($urandom_range(0, 3) != 0));
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? (mem_q[0].addr ^ KEY) : 32'h0;
    PCSrcE         = drv_pcsrc;
    PCTargetE      = drv_target;
    imem_req_ready = drv_req_ready;
    InstrF_ready   = drv_instr_ready;
    #1;
    model_step();
    last_acc = imem_req_valid && imem_req_ready;
    if (rv) void'(mem_q.pop_front());
    if (last_acc) mem_q.push_back('{imem_req_addr, cyc + mem_lat});
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst             = 1'b1;
    drv_pcsrc       = 1'b0;
    drv_req_ready   = 1'b0;
    drv_instr_ready = 1'b0;
    drv_target      = 32'h0;
    PCSrcE          = 1'b0;
    PCTargetE       = 32'h0;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    InstrF_ready    = 1'b0;
    mem_q.delete();
    inflight.delete();
    exp_fifo.delete();
    model_pc  = RESET_PC;
    mem_stall = 1'b0;
`ifdef PFQ_PERF_EN
    m_flush = 0;
    m_drop  = 0;
`endif
    #1;
    check("rst_out_valid", 32'(InstrF_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_InstrF", InstrF, 32'h0);
    check("rst_PCF", PCF, 32'h0);
    check("rst_PCPlus4F", PCPlus4F, 32'h0);
`ifdef PFQ_PERF_EN
    check("rst_flush_cnt", pfq_flush_cnt, 32'h0);
    check("rst_drop_cnt", pfq_drop_cnt, 32'h0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_first_valid(input string name, input int c0, input int lat,
                                  input logic [31:0] target);
    int found;
    found = -1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (InstrF_valid) begin
        found = cyc - 1;
        break;
      end
    end
    check({name, "_first_cycle"}, 32'(found), 32'(c0 + 1 + lat + 1));
    check({name, "_first_pc"}, PCF, target);
  endtask

  initial begin
    int n_acc;
    int c0;

    rst = 1'b1;
    PCSrcE = 1'b0; PCTargetE = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; InstrF_ready = 1'b0;

    // {req_ready, instr_ready, exp_req_valid, exp_addr, exp_out_valid, exp_pcf}, latency 1
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b0, 32'h00};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};

    apply_reset();
    mem_lat = 1;
    for (int i = 0; i < 11; i++) begin
      drv_req_ready   = vecs[i].req_ready;
      drv_instr_ready = vecs[i].instr_ready;
      tick();
      check($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].exp_req_valid));
      if (vecs[i].exp_req_valid)
        check($sformatf("tbl%0d_req_addr", i), imem_req_addr, vecs[i].exp_addr);
      check($sformatf("tbl%0d_out_valid", i), 32'(InstrF_valid), 32'(vecs[i].exp_out_valid));
      if (vecs[i].exp_out_valid) begin
        check($sformatf("tbl%0d_pcf", i), PCF, vecs[i].exp_pcf);
        check($sformatf("tbl%0d_pc4", i), PCPlus4F, vecs[i].exp_pcf + 32'd4);
      end
    end

    // Backpressure: exactly DEPTH requests, then an ordered drain
    apply_reset();
    mem_lat = 1; drv_req_ready = 1'b1; drv_instr_ready = 1'b0;
    n_acc = 0;
    repeat (10) begin
      tick();
      n_acc += int'(last_acc);
    end
    check("bp_accepts", 32'(n_acc), 32'd4);
    check("bp_req_valid_held", 32'(imem_req_valid), 32'd0);
    check("bp_out_valid", 32'(InstrF_valid), 32'd1);
    drv_instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("bp_drain%0d_valid", i), 32'(InstrF_valid), 32'd1);
      check($sformatf("bp_drain%0d_pc", i), PCF, 32'(i * 4));
    end
    repeat (6) tick();

    // Redirect with three stale requests in flight, no response in the redirect cycle
    apply_reset();
    drv_req_ready = 1'b1; drv_instr_ready = 1'b1; mem_lat = 4;
    repeat (3) tick();
    mem_lat = 3; drv_pcsrc = 1'b1; drv_target = 32'h100; c0 = cyc;
    tick();
    drv_pcsrc = 1'b0;
    wait_first_valid("rd3", c0, 3, 32'h100);
`ifdef PFQ_PERF_EN
    check("rd3_drop_cnt", pfq_drop_cnt, 32'd3);
`endif
    repeat (6) tick();

    // Redirect coinciding with a response while two requests are outstanding
    apply_reset();
    drv_req_ready = 1'b1; drv_instr_ready = 1'b1; mem_lat = 2;
    repeat (2) tick();
    drv_pcsrc = 1'b1; drv_target = 32'h200; c0 = cyc;
    tick();
    drv_pcsrc = 1'b0;
    wait_first_valid("rr", c0, 2, 32'h200);
    repeat (4) tick();

    // Address wrap at the top of the 32-bit space
    apply_reset();
    drv_req_ready = 1'b1; drv_instr_ready = 1'b1; mem_lat = 1;
    drv_pcsrc = 1'b1; drv_target = 32'hFFFF_FFFC;
    tick();
    drv_pcsrc = 1'b0;
    tick();
    check("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_acc0", 32'(last_acc), 32'd1);
    tick();
    check("wrap_addr1", imem_req_addr, 32'h0000_0000);
    tick();
    check("wrap_pcf", PCF, 32'hFFFF_FFFC);
    check("wrap_pc4", PCPlus4F, 32'h0000_0000);
    repeat (4) tick();

    // Reset while two entries are queued and one request is in flight
    apply_reset();
    drv_req_ready = 1'b1; drv_instr_ready = 1'b0; mem_lat = 1;
    repeat (3) tick();
    apply_reset();
    drv_req_ready = 1'b1; drv_instr_ready = 1'b1;
    tick();
    check("mr_restart_addr", imem_req_addr, RESET_PC);
    check("mr_restart_acc", 32'(last_acc), 32'd1);
    repeat (6) tick();

    // Randomized traffic against the reference model
    apply_reset();
    mem_stall = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drv_req_ready   = ($urandom_range(0, 3) != 0);
      drv_instr_ready = ($urandom_range(0, 3) != 0);
      drv_pcsrc       = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0:       drv_target = $urandom & 32'hFFFF_FFFC;
        1:       drv_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
        default: drv_target = 32'($urandom_range(0, 255) * 4);
      endcase
      if ($urandom_range(0, 31) == 0) mem_lat = $urandom_range(1, 4);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
